// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and the rotating priority search for the decoder round-robin arbiter.
package decoder_rr_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } winner_t;

  // Scan from ptr upward with wrap; walking the offsets high-to-low lets the
  // nearest set bit overwrite farther ones, so no early exit is needed.
  function automatic winner_t pick_winner(input logic [NUM_REQ-1:0] req,
                                          input logic [SEL_W-1:0]   ptr);
    winner_t          w;
    logic [SEL_W-1:0] idx;
    w = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        w.found = 1'b1;
        w.idx   = idx;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/Decoder3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low while disabled.
module Decoder3to8 (
  input  logic [2:0] a,
  input  logic       en,
  output logic [7:0] D
);

  assign D = en ? (8'b1 << a) : 8'b0;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter granting one shared 3-to-8 decoder to 8 requesters,
// with hold timeout and a one-cycle dead gap between owners.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter  int MAX_HOLD = 16,
  localparam int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 done,
  output logic [SEL_W-1:0]     a,
  output logic                 en,
  output logic [NUM_REQ-1:0]   D,
  output logic                 busy,
  output logic                 timeout
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  winner_t          win;

  assign win = pick_winner(req, ptr_q);

  // NOTE: every next-state signal gets its hold value first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        if (win.found) begin
          a_d     = win.idx;
          cnt_d   = '0;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (done || !req[a_q]) begin
          state_d = GAP;
          ptr_d   = a_q + SEL_W'(1);
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d   = GAP;
          ptr_d     = a_q + SEL_W'(1);
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      a_q       <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Enable is decoded straight from the state flops, so it stays glitch-free.
  assign a       = a_q;
  assign en      = (state_q == GRANT);
  assign busy    = (state_q != IDLE);
  assign timeout = timeout_q;

  Decoder3to8 u_dec (
    .a  (a_q),
    .en (en),
    .D  (D)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench for decoder_rr_arbiter: expected outputs are queued per
// driven cycle and compared on the following falling edge.
module tb_decoder_rr_arbiter;

  localparam int HOLD = 16;

  typedef struct {
    logic [2:0] a;
    logic       en;
    logic       busy;
    logic       to;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] a;
  logic       en;
  logic [7:0] D;
  logic       busy;
  logic       timeout;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  decoder_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .a       (a),
    .en      (en),
    .D       (D),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be after that edge.
  task automatic step(input logic [7:0] r, input logic d, input logic rs,
                      input logic [2:0] ea, input logic een, input logic eb,
                      input logic et);
    exp_t e;
    req  = r;
    done = d;
    rst  = rs;
    e.a = ea; e.en = een; e.busy = eb; e.to = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] exp_d;
      e     = sb.pop_front();
      exp_d = e.en ? (8'b1 << e.a) : 8'b0;
      check("a",       32'(a),       32'(e.a));
      check("en",      32'(en),      32'(e.en));
      check("D",       32'(D),       32'(exp_d));
      check("busy",    32'(busy),    32'(e.busy));
      check("timeout", 32'(timeout), 32'(e.to));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Reset, single requester, release and re-grant after one gap cycle.
    step(8'h00, 0, 1, 3'd0, 0, 0, 0);
    step(8'h00, 0, 1, 3'd0, 0, 0, 0);
    step(8'h08, 0, 0, 3'd3, 1, 1, 0);
    step(8'h08, 1, 0, 3'd3, 0, 1, 0);
    step(8'h08, 0, 0, 3'd3, 1, 1, 0);
    step(8'h08, 1, 0, 3'd3, 0, 1, 0);
    step(8'h00, 0, 0, 3'd3, 0, 0, 0);

    // Round-robin through all requesters with a gap between each owner.
    step(8'h00, 0, 1, 3'd0, 0, 0, 0);
    step(8'hFF, 0, 0, 3'd0, 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step(8'hFF, 1, 0, 3'(k - 1), 0, 1, 0);
      step(8'hFF, 0, 0, 3'(k % 8), 1, 1, 0);
    end
    step(8'hFF, 1, 0, 3'd0, 0, 1, 0);
    step(8'h00, 0, 0, 3'd0, 0, 0, 0);

    // Hold timeout: 16 granted cycles, then a timeout pulse with en low.
    step(8'h01, 0, 0, 3'd0, 1, 1, 0);
    for (int k = 0; k < HOLD - 1; k++) step(8'h01, 0, 0, 3'd0, 1, 1, 0);
    step(8'h01, 0, 0, 3'd0, 0, 1, 1);
    step(8'h01, 0, 0, 3'd0, 1, 1, 0);

    // done coinciding with expiry is an ordinary release.
    for (int k = 0; k < HOLD - 1; k++) step(8'h01, 0, 0, 3'd0, 1, 1, 0);
    step(8'h01, 1, 0, 3'd0, 0, 1, 0);
    step(8'h00, 0, 0, 3'd0, 0, 0, 0);

    // Abandon by owner 6, wrap from ptr 7 to requester 0.
    step(8'h41, 0, 0, 3'd6, 1, 1, 0);
    step(8'h01, 0, 0, 3'd6, 0, 1, 0);
    step(8'h01, 0, 0, 3'd0, 1, 1, 0);
    step(8'h01, 1, 0, 3'd0, 0, 1, 0);
    // done during GAP is ignored.
    step(8'h01, 1, 0, 3'd0, 1, 1, 0);

    // Reset in the middle of a grant to requester 5.
    step(8'h20, 0, 0, 3'd0, 0, 1, 0);
    step(8'h20, 0, 0, 3'd5, 1, 1, 0);
    step(8'h20, 0, 0, 3'd5, 1, 1, 0);
    step(8'h20, 0, 1, 3'd0, 0, 0, 0);
    step(8'hFF, 0, 0, 3'd0, 1, 1, 0);
    step(8'hFF, 1, 0, 3'd0, 0, 1, 0);
    step(8'hFF, 0, 0, 3'd1, 1, 1, 0);

    @(negedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
